// File: rtl/sha_apb_loader.sv
// APB master feeding pre-padded 512-bit blocks into the sha2apb core and streaming back the digest.
// Define SHA_LDR_IRQ_EN to wait on int_i instead of polling the status register.
module sha_apb_loader #(
  parameter logic [11:0] MSG_BASE  = 12'h000,
  parameter logic [11:0] CTRL_ADDR = 12'h040,
  parameter logic [11:0] STAT_ADDR = 12'h044,
  parameter logic [11:0] DIG_BASE  = 12'h080,
  parameter int unsigned POLL_MAX  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic [31:0] blk_data,
  input  logic        blk_last,
  output logic        dig_valid,
  input  logic        dig_ready,
  output logic [31:0] dig_data,
  output logic        dig_last,
  output logic [11:0] PADDR_o,
  output logic [31:0] PWDATA_o,
  output logic        PWRITE_o,
  output logic        PSEL_o,
  output logic        PENABLE_o,
  input  logic [31:0] PRDATA_i,
  input  logic        PREADY_i,
  input  logic        PSLVERR_i,
  input  logic        int_i,
  output logic        busy_o,
  output logic        err_o,
  input  logic        err_clr_i
);

  localparam int unsigned PCW = $clog2(POLL_MAX * 16 + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MSG_WR, S_CTRL_WR, S_POLL, S_WAIT_IRQ, S_DIG_RD, S_DIG_OUT, S_ERR
  } state_t;

  // PH_GAP is the idle cycle forced between two transfers issued from APB states
  typedef enum logic [1:0] {PH_SETUP, PH_ACCESS, PH_GAP} phase_t;

  state_t         state, state_d;
  phase_t         ph, ph_d;
  logic [3:0]     cnt, cnt_d;
  logic [2:0]     dig_idx, dig_idx_d;
  logic           first, first_d;
  logic           last_q, last_d;
  logic [31:0]    word_q, word_d;
  logic [31:0]    dig_q, dig_d;
  logic [PCW-1:0] poll_cnt, poll_d;
  logic           live;

  logic           apb_state, psel, penable, xfer_done;
  logic [11:0]    addr;
  logic [31:0]    wdata;
  logic           wr;

`ifndef SHA_LDR_IRQ_EN
  logic unused_irq;
  assign unused_irq = int_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ph       <= PH_SETUP;
      cnt      <= '0;
      dig_idx  <= '0;
      first    <= 1'b1;
      last_q   <= 1'b0;
      word_q   <= '0;
      dig_q    <= '0;
      poll_cnt <= '0;
      live     <= 1'b0;
    end else begin
      state    <= state_d;
      ph       <= ph_d;
      cnt      <= cnt_d;
      dig_idx  <= dig_idx_d;
      first    <= first_d;
      last_q   <= last_d;
      word_q   <= word_d;
      dig_q    <= dig_d;
      poll_cnt <= poll_d;
      live     <= 1'b1;
    end
  end

  assign apb_state = (state == S_MSG_WR) || (state == S_CTRL_WR) ||
                     (state == S_POLL)   || (state == S_DIG_RD);
  assign psel      = apb_state && (ph != PH_GAP);
  assign penable   = apb_state && (ph == PH_ACCESS);
  assign xfer_done = penable && PREADY_i;

  always_comb begin
    addr  = '0;
    wdata = '0;
    wr    = 1'b0;
    case (state)
      S_MSG_WR: begin
        addr  = MSG_BASE + {6'd0, cnt, 2'd0};
        wdata = word_q;
        wr    = 1'b1;
      end
      S_CTRL_WR: begin
        addr  = CTRL_ADDR;
        wdata = {30'd0, first, 1'b1};
        wr    = 1'b1;
      end
      S_POLL:   addr = STAT_ADDR;
      S_DIG_RD: addr = DIG_BASE + {7'd0, dig_idx, 2'd0};
      default:  addr = '0;
    endcase
  end

  assign PSEL_o    = psel;
  assign PENABLE_o = penable;
  assign PADDR_o   = psel ? addr  : '0;
  assign PWDATA_o  = psel ? wdata : '0;
  assign PWRITE_o  = psel && wr;

  assign blk_ready = live && (state == S_IDLE);
  assign dig_valid = (state == S_DIG_OUT);
  assign dig_data  = dig_q;
  assign dig_last  = dig_valid && (dig_idx == 3'd7);
  assign busy_o    = (state != S_IDLE) && (state != S_ERR);
  assign err_o     = (state == S_ERR);

  always_comb begin
    state_d   = state;
    ph_d      = ph;
    cnt_d     = cnt;
    dig_idx_d = dig_idx;
    first_d   = first;
    last_d    = last_q;
    word_d    = word_q;
    dig_d     = dig_q;
    poll_d    = poll_cnt;

    if (apb_state) begin
      if (ph == PH_GAP)        ph_d = PH_SETUP;
      else if (ph == PH_SETUP) ph_d = PH_ACCESS;
    end

    if (xfer_done && PSLVERR_i) begin
      state_d = S_ERR;
      ph_d    = PH_SETUP;
    end else if (xfer_done) begin
      case (state)
        S_MSG_WR: begin
          cnt_d = cnt + 4'd1;
          if (cnt == 4'd15) begin
            state_d = S_CTRL_WR;
            ph_d    = PH_GAP;
          end else begin
            state_d = S_IDLE;
            ph_d    = PH_SETUP;
          end
        end
        S_CTRL_WR: begin
          first_d = 1'b0;
`ifdef SHA_LDR_IRQ_EN
          state_d = S_WAIT_IRQ;
          ph_d    = PH_SETUP;
          poll_d  = '0;
`else
          state_d = S_POLL;
          ph_d    = PH_GAP;
`endif
        end
        S_POLL: begin
          if (PRDATA_i[0]) begin
            poll_d = '0;
            if (last_q) begin
              state_d   = S_DIG_RD;
              dig_idx_d = '0;
              ph_d      = PH_GAP;
            end else begin
              state_d = S_IDLE;
              ph_d    = PH_SETUP;
            end
          end else begin
`ifdef SHA_LDR_IRQ_EN
            state_d = S_ERR;
            ph_d    = PH_SETUP;
`else
            if (poll_cnt == PCW'(POLL_MAX - 1)) begin
              state_d = S_ERR;
              ph_d    = PH_SETUP;
            end else begin
              poll_d = poll_cnt + PCW'(1);
              ph_d   = PH_GAP;
            end
`endif
          end
        end
        S_DIG_RD: begin
          dig_d   = PRDATA_i;
          state_d = S_DIG_OUT;
          ph_d    = PH_SETUP;
        end
        default: ;
      endcase
    end else begin
      case (state)
        S_IDLE: begin
          if (blk_valid && blk_ready) begin
            word_d  = blk_data;
            state_d = S_MSG_WR;
            ph_d    = PH_SETUP;
            if (cnt == 4'd15) last_d = blk_last;
          end
        end
`ifdef SHA_LDR_IRQ_EN
        S_WAIT_IRQ: begin
          if (int_i) begin
            state_d = S_POLL;
            ph_d    = PH_SETUP;
            poll_d  = '0;
          end else if (poll_cnt == PCW'(POLL_MAX * 16 - 1)) begin
            state_d = S_ERR;
          end else begin
            poll_d = poll_cnt + PCW'(1);
          end
        end
`endif
        S_DIG_OUT: begin
          if (dig_ready) begin
            if (dig_idx == 3'd7) begin
              first_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              dig_idx_d = dig_idx + 3'd1;
              state_d   = S_DIG_RD;
            end
          end
        end
        S_ERR: begin
          if (err_clr_i) begin
            state_d   = S_IDLE;
            ph_d      = PH_SETUP;
            cnt_d     = '0;
            dig_idx_d = '0;
            poll_d    = '0;
            first_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_apb_loader.sv
// Directed bench for sha_apb_loader: stub sha2apb slave with wait states, error injection and digest table.
module tb_sha_apb_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        blk_valid, blk_ready, blk_last;
  logic [31:0] blk_data;
  logic        dig_valid, dig_ready, dig_last;
  logic [31:0] dig_data;
  logic [11:0] PADDR_o;
  logic [31:0] PWDATA_o, PRDATA_i;
  logic        PWRITE_o, PSEL_o, PENABLE_o, PREADY_i, PSLVERR_i;
  logic        int_i, busy_o, err_o, err_clr_i;

  sha_apb_loader #(.POLL_MAX(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data), .dig_last(dig_last),
    .PADDR_o(PADDR_o), .PWDATA_o(PWDATA_o), .PWRITE_o(PWRITE_o), .PSEL_o(PSEL_o),
    .PENABLE_o(PENABLE_o), .PRDATA_i(PRDATA_i), .PREADY_i(PREADY_i), .PSLVERR_i(PSLVERR_i),
    .int_i(int_i), .busy_o(busy_o), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ws = 0;
  int polls_needed = 3;
  int err_at = -1;
  int nwr = 0;
  int stat_reads = 0;
  int acc_cnt = 0;
  int lp = 0;

  logic [31:0] slv_dig [8];
  logic [11:0] la [$];
  logic [31:0] ld [$];
  logic        lw [$];
  int          acc_cyc [$];

  logic [31:0] blk_abc [16] = '{32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018};
  logic [31:0] b2a [16] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  logic [31:0] b2b [16] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                            32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0};
  logic [31:0] dig_abc [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                               32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  logic [31:0] dig_two [8] = '{32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                               32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave stub: ready after ws access cycles, DONE on the polls_needed-th status read
  assign PREADY_i  = (acc_cnt >= ws);
  assign PSLVERR_i = PSEL_o && PENABLE_o && PWRITE_o && (nwr == err_at);

  always_comb begin
    PRDATA_i = 32'hdeadbeef;
    if (PADDR_o == 12'h044)
      PRDATA_i = {31'd0, (stat_reads >= polls_needed - 1)};
    else if (PADDR_o >= 12'h080 && PADDR_o < 12'h0a0)
      PRDATA_i = slv_dig[PADDR_o[4:2]];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (PSEL_o && PENABLE_o && !PREADY_i) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (PSEL_o && PENABLE_o && PREADY_i) begin
      if (PWRITE_o) begin
        nwr <= nwr + 1;
        if (PADDR_o == 12'h040) stat_reads <= 0;
      end else if (PADDR_o == 12'h044) begin
        stat_reads <= stat_reads + 1;
      end
    end
    if (blk_valid && blk_ready) acc_cyc.push_back(cyc);
  end

  // Protocol monitor and transfer log
  logic        prev_psel = 1'b0, prev_done = 1'b0, s_wr = 1'b0;
  logic [11:0] s_addr = '0;
  logic [31:0] s_data = '0;
  int          pen = 0;

  always @(negedge clk) begin
    if (PSEL_o && !PENABLE_o) begin
      check("apb idle before setup", prev_psel, 1'b0);
      s_addr <= PADDR_o;
      s_data <= PWDATA_o;
      s_wr   <= PWRITE_o;
      pen    <= 0;
    end else if (PSEL_o && PENABLE_o) begin
      check("apb access after setup", prev_psel && !prev_done, 1'b1);
      check("apb stable", {s_wr, s_addr, s_data}, {PWRITE_o, PADDR_o, PWDATA_o});
      if (PREADY_i) begin
        check("penable cycles", pen + 1, ws + 1);
        la.push_back(PADDR_o);
        ld.push_back(PWDATA_o);
        lw.push_back(PWRITE_o);
      end
      pen <= pen + 1;
    end
    prev_psel <= PSEL_o;
    prev_done <= PSEL_o && PENABLE_o && PREADY_i;
  end

  task automatic send_word(input logic [31:0] d, input logic l);
    int n = 0;
    blk_valid = 1'b1;
    blk_data  = d;
    blk_last  = l;
    while (!blk_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("blk_ready", blk_ready, 1'b1);
    @(negedge clk);
    blk_valid = 1'b0;
    blk_last  = 1'b0;
  endtask

  task automatic send_block(input logic [31:0] w [16], input logic l, input logic junk);
    for (int i = 0; i < 16; i++) send_word(w[i], (i == 15) ? l : junk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("wait idle", busy_o, 1'b0);
  endtask

  task automatic get_digest(input logic [31:0] e [8], input int stall_word);
    for (int k = 0; k < 8; k++) begin
      int n = 0;
      dig_ready = 1'b0;
      while (!dig_valid && n < 500) begin
        @(negedge clk);
        n++;
      end
      check("dig_valid", dig_valid, 1'b1);
      check("dig_data", dig_data, e[k]);
      check("dig_last", dig_last, (k == 7));
      if (k == stall_word) begin
        logic [31:0] d0 = dig_data;
        int psel_seen = 0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (PSEL_o) psel_seen++;
          check("stall dig_valid", dig_valid, 1'b1);
          check("stall dig_data", dig_data, d0);
        end
        check("apb quiet during stall", psel_seen, 0);
      end
      dig_ready = 1'b1;
      @(negedge clk);
      dig_ready = 1'b0;
    end
  endtask

  task automatic check_msg_log(input logic [31:0] w [16], input logic [31:0] ctrl);
    check("log length msg", (la.size() >= lp + 17 + polls_needed), 1'b1);
    if (la.size() >= lp + 17 + polls_needed) begin
      for (int i = 0; i < 16; i++) begin
        logic [11:0] a = 12'(i * 4);
        check("msg write", {lw[lp], la[lp], ld[lp]}, {1'b1, a, w[i]});
        lp++;
      end
      check("ctrl write", {lw[lp], la[lp], ld[lp]}, {1'b1, 12'h040, ctrl});
      lp++;
      for (int p = 0; p < polls_needed; p++) begin
        check("status read", {lw[lp], la[lp]}, {1'b0, 12'h044});
        lp++;
      end
    end
  endtask

  task automatic check_dig_log();
    check("log length dig", (la.size() >= lp + 8), 1'b1);
    if (la.size() >= lp + 8) begin
      for (int j = 0; j < 8; j++) begin
        logic [11:0] a = 12'h080 + 12'(j * 4);
        check("digest read", {lw[lp], la[lp]}, {1'b0, a});
        lp++;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; blk_valid = 1'b0; blk_data = '0; blk_last = 1'b0;
    dig_ready = 1'b0; err_clr_i = 1'b0; int_i = 1'b0;
    slv_dig = dig_abc;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst flags", {blk_ready, dig_valid, dig_last, PSEL_o, PENABLE_o, PWRITE_o, busy_o, err_o}, 8'h00);
    check("rst dig_data", dig_data, 32'h0);
    check("rst apb bus", {PADDR_o, PWDATA_o}, 44'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post-reset ready/busy", {blk_ready, busy_o}, 2'b10);

    // Single block "abc"
    acc_cyc.delete();
    send_block(blk_abc, 1'b1, 1'b0);
    check("busy after last word", busy_o, 1'b1);
    check("accept spacing", acc_cyc[2] - acc_cyc[1], 3);
    get_digest(dig_abc, -1);
    check("idle after digest", {busy_o, blk_ready, dig_valid}, 3'b010);
    check_msg_log(blk_abc, 32'h3);
    check_dig_log();

    // Two blocks; blk_last on words 0..14 ignored, err_clr_i outside ERR ignored
    slv_dig = dig_two;
    send_block(b2a, 1'b0, 1'b1);
    err_clr_i = 1'b1;
    send_block(b2b, 1'b1, 1'b0);
    err_clr_i = 1'b0;
    get_digest(dig_two, -1);
    check_msg_log(b2a, 32'h3);
    check_msg_log(b2b, 32'h1);
    check_dig_log();

    // Three wait states per access
    ws = 3;
    slv_dig = dig_abc;
    send_block(blk_abc, 1'b1, 1'b0);
    get_digest(dig_abc, -1);
    check_msg_log(blk_abc, 32'h3);
    check_dig_log();
    ws = 0;

    // PSLVERR on the 5th write of a non-first block, then recovery
    send_block(b2a, 1'b0, 1'b0);
    wait_idle();
    check_msg_log(b2a, 32'h3);
    err_at = nwr + 4;
    for (int i = 0; i < 5; i++) send_word(blk_abc[i], 1'b0);
    n = 0;
    while (!err_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("err_o set", err_o, 1'b1);
    check("err outputs", {blk_ready, busy_o, dig_valid}, 3'b000);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (PSEL_o) n++;
    end
    check("no psel in err", n, 0);
    check("err sticky", err_o, 1'b1);
    err_at = -1;
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    @(negedge clk);
    check("after err clear", {err_o, busy_o, blk_ready}, 3'b001);
    lp = la.size();
    send_block(blk_abc, 1'b1, 1'b0);
    get_digest(dig_abc, -1);
    check_msg_log(blk_abc, 32'h3);
    check_dig_log();

    // Downstream stall on digest word 3
    send_block(blk_abc, 1'b1, 1'b0);
    get_digest(dig_abc, 3);
    check_msg_log(blk_abc, 32'h3);
    check_dig_log();

    // Asynchronous reset during the CTRL write of a second block
    send_block(b2a, 1'b0, 1'b0);
    wait_idle();
    send_block(b2b, 1'b1, 1'b0);
    n = 0;
    while (!(PSEL_o && PENABLE_o && PADDR_o == 12'h040) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ctrl access reached", (PSEL_o && PENABLE_o && PADDR_o == 12'h040), 1'b1);
    check("second block ctrl", PWDATA_o, 32'h1);
    #2 rst_n = 1'b0;
    #1 check("async abort", {PSEL_o, PENABLE_o, busy_o}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("after reset release", {busy_o, blk_ready, err_o}, 3'b010);
    lp = la.size();
    send_block(blk_abc, 1'b1, 1'b0);
    get_digest(dig_abc, -1);
    check_msg_log(blk_abc, 32'h3);
    check_dig_log();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sha_apb_loader.md
Name: sha_apb_loader

Overview:
- APB master sitting directly upstream of the sha2apb slave. It turns a word stream of pre-padded 512-bit message blocks into APB register writes, starts each compression and polls for completion.
- After the final block it reads back the 256-bit digest and streams it out as 8 words.
- Message padding is done upstream; this block only moves data and sequences the core.

Parameters:
- MSG_BASE, 12'h000, byte address of message word 0; words at MSG_BASE+4*i, i=0..15
- CTRL_ADDR, 12'h040, control register: bit0 START, bit1 INIT (first block of message)
- STAT_ADDR, 12'h044, status register: bit0 DONE
- DIG_BASE, 12'h080, digest word 0 (H0); words at DIG_BASE+4*j, j=0..7
- POLL_MAX, 255, max status reads per block before timeout error

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- blk_valid  in  1  message word valid
- blk_ready  out  1  message word accepted when valid&ready
- blk_data  in  32  message word, big-endian word order as in the block
- blk_last  in  1  final block of message; sampled only with word 15
- dig_valid  out  1  digest word valid
- dig_ready  in  1  downstream accepts digest word
- dig_data  out  32  digest word, H0 first
- dig_last  out  1  high with the H7 word
- PADDR_o  out  12  APB address
- PWDATA_o  out  32  APB write data
- PWRITE_o  out  1  APB write
- PSEL_o  out  1  APB select
- PENABLE_o  out  1  APB enable
- PRDATA_i  in  32  APB read data
- PREADY_i  in  1  APB ready
- PSLVERR_i  in  1  APB slave error
- int_i  in  1  core interrupt (used only with the optional feature)
- busy_o  out  1  high in any state except IDLE and ERR
- err_o  out  1  sticky error flag
- err_clr_i  in  1  clears the error; returns to IDLE

Behaviour:
- Reset values: all outputs 0; word counter 0; first-block flag 1; poll counter 0; FSM in IDLE.
- APB protocol:
  - Every transfer is a SETUP cycle (PSEL=1, PENABLE=0) followed by ACCESS (PSEL=1, PENABLE=1), held until PREADY_i=1. Minimum 2 cycles.
  - PADDR_o, PWRITE_o and PWDATA_o are stable from SETUP to completion. PSEL_o drops the cycle after completion.
  - Transfers are never back-to-back without a SETUP.
- States:
  - IDLE: blk_ready=1. On accept, latch the word, go to MSG_WR.
  - MSG_WR: write MSG_BASE+4*cnt. On completion, cnt++.
    - If cnt was <15, go to IDLE (blk_ready reasserts one cycle after completion).
    - If cnt was 15, latch blk_last, cnt wraps to 0, go to CTRL_WR.
  - CTRL_WR: write PWDATA = {30'b0, first, 1'b1}, i.e. 0x3 for the first block, 0x1 otherwise. Clear first-block flag. Go to POLL.
  - POLL: read STAT_ADDR; poll counter increments per read.
    - DONE=1: clear poll counter. If the latched last=1, go to DIG_RD with j=0; else go to IDLE.
    - DONE=0 with counter=POLL_MAX: go to ERR.
  - DIG_RD: read DIG_BASE+4*j, capture PRDATA_i into dig_data, go to DIG_OUT.
  - DIG_OUT: dig_valid=1, held stable until dig_ready.
    - On handshake with j<7: j++, back to DIG_RD.
    - On handshake with j=7 (dig_last=1): set first-block flag, go to IDLE.
  - ERR: err_o=1, no APB activity, blk_ready=0, dig_valid=0. err_clr_i returns to IDLE and resets cnt, j, poll counter and first-block flag.
- Boundary rules:
  - PSLVERR_i=1 at completion of any transfer: go to ERR; captured data is discarded.
  - err_clr_i outside ERR is ignored.
  - blk_last on words 0..14 is ignored.
  - Asynchronous reset mid-transfer aborts immediately: PSEL/PENABLE go to 0, state returns to IDLE.
- Throughput: at PREADY=1 the block accepts one message word per 3 cycles.

Optional Feature:
- Macro SHA_LDR_IRQ_EN.
- Defined: POLL is replaced by WAIT_IRQ.
  - No APB traffic while waiting. int_i high (level) for one sampled cycle ends the wait.
  - One STAT_ADDR read then confirms DONE and clears the interrupt. DONE=0 on that read goes to ERR.
  - POLL_MAX bounds the wait in cycles (multiplied by 16).
- Undefined: int_i is unused and status polling applies as described above.

Test Plan:
- Single block "abc" (0x61626380, 14×0, 0x00000018), blk_last=1, PREADY=1 -> 16 writes to 0x000..0x03C, CTRL write 0x3, polls until DONE, digest out ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, dig_last on the 8th word.
- Two-block message (56-byte "abcdbcdecdef...nopq" padded) -> CTRL writes 0x3 then 0x1; digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- PREADY_i low 3 cycles on each access -> address and data stable throughout; PENABLE_o high exactly 4 cycles per transfer; same digest as the single-block test.
- PSLVERR_i on the 5th message write -> err_o=1, blk_ready=0, no further PSEL. err_clr_i pulse -> next 16 words go to 0x000..0x03C and CTRL write is 0x3.
- dig_ready low for 10 cycles on word 3 -> dig_data/dig_valid stable; no APB read issued until the handshake.
- rst_n asserted during CTRL_WR ACCESS -> PSEL_o/PENABLE_o drop asynchronously; after release busy_o=0, blk_ready=1, and the next block uses CTRL 0x3.
